mem_burst_responder: RTL

On-chip, BRAM-backed responder for the burst read/write request protocol issued by the frame FIFO read/write initiators. It serves both request channels from a single memory array.
- Accepts wr_burst_req/rd_burst_req, arbitrates between them and generates wr_burst_data_req, rd_burst_data_valid and the finish pulses.
- Used in place of the external DDR controller in simulation and in small-frame builds.
- Sits entirely in the mem_clk domain.

---
 rtl/mem_burst_responder_pkg.sv | 18 +
 rtl/mem_burst_responder_if.sv | 34 +++
 rtl/mem_burst_responder_sdp_ram.sv | 23 ++
 rtl/mem_burst_responder.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_burst_responder_pkg.sv
// Shared types and constants for the BRAM-backed burst responder.
package mem_burst_pkg;

  localparam int unsigned BEAT_CNT_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    WR_TAIL,
    RD_BEAT,
    RD_TAIL,
    FIN
  } state_e;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/mem_burst_responder_if.sv
// Burst read/write request bus between a frame initiator and the responder.
interface mem_burst_responder_if #(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 25,
  parameter int unsigned BUSRT_BITS    = 10
);
  logic                     wr_burst_req;
  logic [BUSRT_BITS-1:0]    wr_burst_len;
  logic [ADDR_BITS-1:0]     wr_burst_addr;
  logic                     wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     wr_burst_finish;
  logic                     rd_burst_req;
  logic [BUSRT_BITS-1:0]    rd_burst_len;
  logic [ADDR_BITS-1:0]     rd_burst_addr;
  logic                     rd_burst_data_valid;
  logic [MEM_DATA_BITS-1:0] rd_burst_data;
  logic                     rd_burst_finish;
  logic                     busy;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  wr_burst_data_req, wr_burst_finish,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish, busy
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output wr_burst_data_req, wr_burst_finish,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish, busy
  );
endinterface

// File: rtl/mem_burst_responder_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a 1-cycle registered read.
module burst_sdp_ram #(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned DEPTH_BITS    = 12
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DEPTH_BITS-1:0]    waddr,
  input  logic [MEM_DATA_BITS-1:0] wdata,
  input  logic                     re,
  input  logic [DEPTH_BITS-1:0]    raddr,
  output logic [MEM_DATA_BITS-1:0] rdata
);
  logic [MEM_DATA_BITS-1:0] mem [2**DEPTH_BITS];
  logic [MEM_DATA_BITS-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_burst_responder.sv
// Burst request responder serving the write and read channels from one on-chip array.
module mem_burst_responder
  import mem_burst_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 25,
  parameter int unsigned BUSRT_BITS    = BEAT_CNT_BITS,
  parameter int unsigned DEPTH_BITS    = 12
) (
  input  logic                  mem_clk,
  input  logic                  rst_n,
  mem_burst_responder_if.slave  bus
);
  state_e                   state_q, state_d;
  logic [DEPTH_BITS-1:0]    base_q, base_d;
  logic [BUSRT_BITS-1:0]    len_q, len_d;
  logic [BUSRT_BITS-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [DEPTH_BITS-1:0]    wptr_q, wptr_d;
  logic                     chan_q, chan_d;
  logic                     pref_q, pref_d;
  logic                     grant;
  logic                     wr_pend_q;
  logic                     wr_req_q, rd_valid_q, wr_fin_q, rd_fin_q, busy_q;
  logic [MEM_DATA_BITS-1:0] ram_rdata;
  logic [DEPTH_BITS-1:0]    ram_waddr, ram_raddr;
  logic                     ram_re;

  // Upper address bits select nothing: the array wraps on the low bits.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.wr_burst_addr[ADDR_BITS-1:DEPTH_BITS],
                            bus.rd_burst_addr[ADDR_BITS-1:DEPTH_BITS]};

  assign cnt_inc = cnt_q + {{(BUSRT_BITS-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    chan_d  = chan_q;
    pref_d  = pref_q;
    grant   = GRANT_WR;
    if (wr_pend_q) wptr_d = wptr_q + {{(DEPTH_BITS-1){1'b0}}, 1'b1};
    case (state_q)
      IDLE: begin
        if (bus.wr_burst_req || bus.rd_burst_req) begin
          // Preference only flips when both channels actually contend.
          if (bus.wr_burst_req && bus.rd_burst_req) begin
            grant  = pref_q;
            pref_d = (pref_q == GRANT_WR) ? GRANT_RD : GRANT_WR;
          end else begin
            grant = bus.wr_burst_req ? GRANT_WR : GRANT_RD;
          end
          chan_d = grant;
          cnt_d  = '0;
          wptr_d = '0;
          if (grant == GRANT_WR) begin
            base_d = bus.wr_burst_addr[DEPTH_BITS-1:0];
            len_d  = bus.wr_burst_len;
          end else begin
            base_d = bus.rd_burst_addr[DEPTH_BITS-1:0];
            len_d  = bus.rd_burst_len;
          end
          if (len_d == '0)              state_d = FIN;
          else if (grant == GRANT_WR)   state_d = WR_BEAT;
          else                          state_d = RD_BEAT;
        end
      end
      WR_BEAT: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) state_d = WR_TAIL;
      end
      RD_BEAT: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) state_d = RD_TAIL;
      end
      WR_TAIL, RD_TAIL: state_d = FIN;
      FIN:              state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      chan_q     <= GRANT_WR;
      pref_q     <= GRANT_WR;
      wr_pend_q  <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_fin_q   <= 1'b0;
      rd_fin_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      chan_q     <= chan_d;
      pref_q     <= pref_d;
      wr_pend_q  <= wr_req_q;
      wr_req_q   <= (state_d == WR_BEAT);
      rd_valid_q <= (state_q == RD_BEAT);
      wr_fin_q   <= (state_d == FIN) && (chan_d == GRANT_WR);
      rd_fin_q   <= (state_d == FIN) && (chan_d == GRANT_RD);
      busy_q     <= (state_d != IDLE);
    end
  end

  // Write data trails its beat request by one cycle, hence the separate write pointer.
  assign ram_waddr = base_q + wptr_q;
  assign ram_raddr = base_q + DEPTH_BITS'(cnt_q);
  assign ram_re    = (state_q == RD_BEAT);

  burst_sdp_ram #(
    .MEM_DATA_BITS (MEM_DATA_BITS),
    .DEPTH_BITS    (DEPTH_BITS)
  ) u_ram (
    .clk   (mem_clk),
    .we    (wr_pend_q),
    .waddr (ram_waddr),
    .wdata (bus.wr_burst_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign bus.wr_burst_data_req   = wr_req_q;
  assign bus.wr_burst_finish     = wr_fin_q;
  assign bus.rd_burst_data_valid = rd_valid_q;
  assign bus.rd_burst_data       = rd_valid_q ? ram_rdata : '0;
  assign bus.rd_burst_finish     = rd_fin_q;
  assign bus.busy                = busy_q;
endmodule
